// File: rtl/io_pkg.sv
// +--------------------------------------------------------------------+
// | io_pkg: shared front-panel input FSM encodings and board timing.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package io_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int unsigned LONG_1S       = CLK_HZ;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +--------------------------------------------------------------------+
// | sync_2ff: two-stage synchroniser, async active-low reset.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// +--------------------------------------------------------------------+
// | button_debounce: sync + debounce one push-button pin, emit level,  |
// | press/release/long-press pulses.  Rev 1.0                          |
// +--------------------------------------------------------------------+
`default_nettype none

module button_debounce
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LCNT_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG_CYCLES);

  logic btn_sync;
  logic act;

  btn_state_e        state_q,     state_d;
  logic [DCNT_W-1:0] dcnt_q,      dcnt_d;
  logic [LCNT_W-1:0] lcnt_q,      lcnt_d;
  logic              long_done_q, long_done_d;
  logic              level_q,     level_d;
  logic              press_q,     press_d;
  logic              release_q,   release_d;
  logic              long_q,      long_d;

  logic [LCNT_W-1:0] lcnt_inc;
  logic              long_hit;

  // Flops idle at the released pin level so reset never looks like a press.
  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn),
    .o_q     (btn_sync)
  );

  assign act      = ACTIVE_LOW ? ~btn_sync : btn_sync;
  assign lcnt_inc = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + LCNT_W'(1);
  assign long_hit = (lcnt_q == LCNT_LAST) && !long_done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RELEASED;
      dcnt_q      <= '0;
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      RELEASED: begin
        if (act) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end

      PRESS_WAIT: begin
        if (!act) begin
          state_d = RELEASED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          lcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end

      PRESSED: begin
        lcnt_d = lcnt_inc;
        if (long_hit) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
        if (!act) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end

      RELEASE_WAIT: begin
        // Long-press timing carries on while a release is being qualified,
        // but is dropped on the cycle the release is accepted.
        if (act || (dcnt_q != DCNT_LAST)) begin
          lcnt_d = lcnt_inc;
          if (long_hit) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
        end
        if (act) begin
          state_d = PRESSED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d     = RELEASED;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end

      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// Randomised + directed bench for button_debounce against a run-length
// reference model (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1).
`default_nettype none

module tb_button_debounce;

  localparam int unsigned D = 8;
  localparam int unsigned L = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b1;
  logic o_level, o_press, o_release, o_long;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_btn     (btn),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_long    (o_long)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: pin seen two edges late; the debounced level flips once
  // the opposite level has been seen on D+1 consecutive edges. o_long fires
  // L edges after the press pulse if the level is still held.
  logic m_s1, m_s2, m_level, m_press, m_release, m_long, m_long_done;
  int   m_run, m_held;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1;
    m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
    m_long_done = 1'b0; m_run = 0; m_held = 0;
  endtask

  task automatic model_edge(input logic pin);
    logic a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a    = ~m_s2;
    m_s2 = m_s1;
    m_s1 = pin;
    m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
    if (a != m_level) m_run++;
    else              m_run = 0;
    if (m_run == int'(D) + 1) begin
      m_run = 0;
      if (a) begin
        m_level = 1'b1; m_press = 1'b1; m_held = 0; m_long_done = 1'b0;
      end else begin
        m_level = 1'b0; m_release = 1'b1;
      end
    end else if (m_level) begin
      m_held++;
      if (m_held == int'(L) && !m_long_done) begin
        m_long = 1'b1;
        m_long_done = 1'b1;
      end
    end
  endtask

  int cyc = 0;
  int press_cnt, release_cnt, long_cnt, press_at, release_at, long_at;

  task automatic clr();
    press_cnt = 0; release_cnt = 0; long_cnt = 0;
    press_at = -1; release_at = -1; long_at = -1;
  endtask

  task automatic cmp_outputs(input string where);
    check({where, ".level"},   o_level,   m_level);
    check({where, ".press"},   o_press,   m_press);
    check({where, ".release"}, o_release, m_release);
    check({where, ".long"},    o_long,    m_long);
  endtask

  task automatic step(input logic pin, input string where);
    btn = pin;
    @(posedge clk);
    model_edge(pin);
    cyc++;
    @(negedge clk);
    cmp_outputs(where);
    if (o_press)   begin press_cnt++;   if (press_at < 0)   press_at = cyc;   end
    if (o_release) begin release_cnt++; if (release_at < 0) release_at = cyc; end
    if (o_long)    begin long_cnt++;    if (long_at < 0)    long_at = cyc;    end
  endtask

  task automatic hold(input logic pin, input int n, input string where);
    for (int i = 0; i < n; i++) step(pin, where);
  endtask

  int t0;

  initial begin
    model_reset();
    clr();

    // 1: reset held with pin low, then release
    hold(1'b0, 4, "t1_rst");
    rst_n = 1'b1;
    t0 = cyc;
    clr();
    hold(1'b0, 15, "t1");
    check("t1_press_lat", press_at - (t0 + 1), D + 2);
    check("t1_level", o_level, 1'b1);
    hold(1'b1, 20, "t1_rel");

    // 2: clean press, release 50 clocks later
    clr();
    t0 = cyc;
    hold(1'b0, 50, "t2_hold");
    hold(1'b1, 20, "t2_rel");
    check("t2_press_cnt", press_cnt, 1);
    check("t2_press_lat", press_at - (t0 + 1), D + 2);
    check("t2_release_cnt", release_cnt, 1);
    check("t2_release_lat", release_at - (t0 + 51), D + 2);
    check("t2_long_cnt", long_cnt, 1);
    check("t2_long_ofs", long_at - press_at, L);

    // 3: bounce rejected
    clr();
    hold(1'b0, 5, "t3");
    hold(1'b1, 1, "t3");
    hold(1'b0, 5, "t3");
    hold(1'b1, 20, "t3");
    check("t3_press_cnt", press_cnt, 0);
    check("t3_release_cnt", release_cnt, 0);

    // 4: release glitch while held
    clr();
    hold(1'b0, 20, "t4");
    hold(1'b1, 3, "t4_glitch");
    hold(1'b0, 40, "t4");
    check("t4_press_cnt", press_cnt, 1);
    check("t4_release_cnt", release_cnt, 0);
    check("t4_long_cnt", long_cnt, 1);
    check("t4_long_ofs", long_at - press_at, L);
    hold(1'b1, 20, "t4_rel");

    // 5: long hold, single long pulse
    clr();
    hold(1'b0, 200, "t5");
    check("t5_long_cnt", long_cnt, 1);
    hold(1'b1, 20, "t5_rel");

    // 6: reset while pressed
    clr();
    hold(1'b0, 20, "t6");
    check("t6_pressed", o_level, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_level", o_level, 1'b0);
    cmp_outputs("t6_async");
    hold(1'b0, 2, "t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    t0 = cyc;
    hold(1'b0, 15, "t6_after");
    check("t6_release_cnt", release_cnt, 0);
    check("t6_press_lat", press_at - (t0 + 1), D + 2);
    hold(1'b1, 20, "t6_rel");

    // Randomised segments, occasional long holds and resets
    for (int s = 0; s < 300; s++) begin
      int len;
      logic pin;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 60))
                                        : int'($urandom_range(1, 12));
      pin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_outputs("rnd_rst");
        hold(pin, 2, "rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      hold(pin, len, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
